// File: rtl/kernel_a_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_a_ctrl_pkg
// Description : Shared FSM state encoding and default sizing constants for
//               the kernel_A stream controller.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_a_ctrl_pkg;

  // Default pipeline depth of kernelTop_kernel_A and work-item counter width
  localparam int unsigned c_DEF_LAT  = 4;
  localparam int unsigned c_DEF_CNTW = 16;

  // Controller run state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_t;

endpackage : kernel_a_ctrl_pkg
`default_nettype wire

// File: rtl/kernel_a_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : kernel_a_valid_pipe
// Description : LAT-deep valid shadow of the kernel_A datapath. Shifts only
//               when enabled so it tracks the stall-gated datapath exactly.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_a_valid_pipe
  import kernel_a_ctrl_pkg::*;
#(
  parameter int unsigned LAT = c_DEF_LAT
) (
  input  logic           clk,
  input  logic           rst,     // asynchronous, active-low
  input  logic           i_clr,   // synchronous flush, wins over shift
  input  logic           i_en,    // shift enable (datapath not stalled)
  input  logic           i_din,   // serial in: item accepted this cycle
  output logic [LAT-1:0] o_vld
);

  logic [LAT-1:0] r_vld;

  // Valid bits advance one stage per unstalled cycle; a non-accept loads a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else if (i_clr) begin
      r_vld <= '0;
    end else if (i_en) begin
      for (int k = LAT - 1; k > 0; k--) begin
        r_vld[k] <= r_vld[k-1];
      end
      r_vld[0] <= i_din;
    end
  end

  assign o_vld = r_vld;

endmodule : kernel_a_valid_pipe
`default_nettype wire

// File: rtl/kernel_a_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kernel_a_stream_ctrl
// Description : Run/flow controller for the kernel_A pipeline. Issues n_items
//               operand pairs, tracks them through the LAT-deep datapath,
//               back-pressures via dp_stall and retires results downstream.
//               Data is passed straight through from the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_a_stream_ctrl
  import kernel_a_ctrl_pkg::*;
#(
  parameter int unsigned DATAW = 32,
  parameter int unsigned LAT   = c_DEF_LAT,
  parameter int unsigned CNTW  = c_DEF_CNTW
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             start,
  input  logic [CNTW-1:0]  n_items,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dp_stall,
  input  logic [DATAW-1:0] dp_vout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data
);

  ctrl_state_t     r_state;
  ctrl_state_t     w_state_nxt;
  logic [CNTW-1:0] r_n_items;
  logic [CNTW-1:0] r_issued;
  logic [CNTW-1:0] r_retired;
  logic [LAT-1:0]  w_vld;
  logic            w_stall;
  logic            w_accept;
  logic            w_retire;
  logic            w_start_ok;
  logic            w_enter_run;

  // Stall only when the last stage holds a result the consumer refuses
  assign w_stall     = w_vld[LAT-1] & ~out_ready;
  assign w_retire    = w_vld[LAT-1] & out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_start_ok  = (r_state == ST_IDLE) & start;
  assign w_enter_run = w_start_ok & (n_items != '0);

  assign dp_stall  = w_stall;
  assign out_valid = w_vld[LAT-1];
  assign out_data  = dp_vout;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs; a zero-length run goes straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (n_items != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = ~w_stall & (r_issued < r_n_items);
        if (r_retired == r_n_items) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Run length is captured only when a start is actually taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n_items <= '0;
    end else if (w_start_ok) begin
      r_n_items <= n_items;
    end
  end

  // Issue/retire counters, restarted at the beginning of every run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issued  <= '0;
      r_retired <= '0;
    end else if (w_enter_run) begin
      r_issued  <= '0;
      r_retired <= '0;
    end else begin
      if (w_accept) begin
        r_issued <= r_issued + 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  kernel_a_valid_pipe #(
    .LAT (LAT)
  ) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_enter_run),
    .i_en  (~w_stall),
    .i_din (w_accept),
    .o_vld (w_vld)
  );

endmodule : kernel_a_stream_ctrl
`default_nettype wire

// File: tb/tb_kernel_a_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_a_stream_ctrl
// Description : Directed bench for kernel_a_stream_ctrl with a stall-gated
//               model of the kernel_A datapath carrying item sequence tags.
//               Cycle 0 of each case is the start cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_a_stream_ctrl;

  localparam int DATAW = 32;
  localparam int LAT   = 4;
  localparam int CNTW  = 16;
  localparam int MAXC  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNTW-1:0]  n_items = '0;
  logic             busy;
  logic             done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             dp_stall;
  logic [DATAW-1:0] dp_vout;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DATAW-1:0] out_data;

  logic [DATAW-1:0] tb_in_data = '0;
  logic [DATAW-1:0] dp_pipe [LAT];

  int n_checks = 0;
  int n_errors = 0;

  logic [MAXC-1:0] v_ir, v_ov, v_st, v_dn, v_bs;
  int n_acc, n_ret;

  always #5 clk = ~clk;

  kernel_a_stream_ctrl #(
    .DATAW (DATAW),
    .LAT   (LAT),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_items   (n_items),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dp_stall  (dp_stall),
    .dp_vout   (dp_vout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Datapath stand-in: LAT stages that freeze while stalled
  always @(posedge clk) begin
    if (!dp_stall) begin
      for (int k = LAT - 1; k > 0; k--) dp_pipe[k] <= dp_pipe[k-1];
      dp_pipe[0] <= tb_in_data;
    end
  end
  assign dp_vout = dp_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One case: drive inputs 1 time unit after each edge, sample 2 units later
  task automatic run_case(input int id, input int n, input int ncyc);
    v_ir = '0; v_ov = '0; v_st = '0; v_dn = '0; v_bs = '0;
    n_acc = 0; n_ret = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      start   = (c == 0) || (id == 5 && c == 2);
      n_items = (id == 5 && c != 0) ? CNTW'(7) : CNTW'(n);
      case (id)
        2:       begin in_valid = 1'b1;        out_ready = !(c >= 6 && c <= 9); end
        4:       begin in_valid = (c % 2 == 1); out_ready = 1'b1; end
        6:       begin in_valid = (c <= 3);     out_ready = (c != 5); end
        default: begin in_valid = 1'b1;        out_ready = 1'b1; end
      endcase
      tb_in_data = DATAW'(n_acc);
      #2;
      v_ir[c] = in_ready;
      v_ov[c] = out_valid;
      v_st[c] = dp_stall;
      v_dn[c] = done;
      v_bs[c] = busy;
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) begin
        check($sformatf("c%0d_order%0d", id, n_ret), out_data, n_ret);
        n_ret++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_outs", {busy, done, in_ready, out_valid, dp_stall}, 5'b0);
    @(negedge clk); rst = 1'b1;

    // n=8 streaming: accepts c1..c8, results c5..c12, counter hits 8 in c13, done c14
    run_case(1, 8, 18);
    check("c1_ov",   v_ov, 32'h0000_1FE0);
    check("c1_ir",   v_ir, 32'h0000_01FE);
    check("c1_done", v_dn, 32'h0000_4000);
    check("c1_busy", v_bs, 32'h0000_7FFE);
    check("c1_nret", n_ret, 8);

    // n=5, out_ready low c6..c9: stall exactly then, remaining results c10..c13
    run_case(2, 5, 20);
    check("c2_stall", v_st, 32'h0000_03C0);
    check("c2_ov",    v_ov, 32'h0000_3FE0);
    check("c2_ir",    v_ir, 32'h0000_003E);
    check("c2_done",  v_dn, 32'h0000_8000);
    check("c2_nret",  n_ret, 5);

    // n=0: done in c1, nothing accepted
    run_case(3, 0, 6);
    check("c3_done", v_dn, 32'h0000_0002);
    check("c3_busy", v_bs, 32'h0000_0002);
    check("c3_ir",   v_ir, 32'h0);
    check("c3_nacc", n_acc, 0);

    // n=6, in_valid on odd cycles: accepts c1..c11 odd, results c5..c15 odd, done c17
    run_case(4, 6, 22);
    check("c4_ov",   v_ov, 32'h0000_AAA0);
    check("c4_ir",   v_ir, 32'h0000_0FFE);
    check("c4_nacc", n_acc, 6);
    check("c4_nret", n_ret, 6);
    check("c4_done", v_dn, 32'h0002_0000);

    // n=3 with a second start (n=7) in RUN: ignored
    run_case(5, 3, 13);
    check("c5_nacc", n_acc, 3);
    check("c5_nret", n_ret, 3);
    check("c5_ov",   v_ov, 32'h0000_00E0);
    check("c5_done", v_dn, 32'h0000_0200);

    // n=10, 3 accepts, then reset mid-cycle while the first result is stalled
    run_case(6, 10, 6);
    check("c6_nacc",  n_acc, 3);
    check("c6_ir",    v_ir, 32'h0000_001E);
    check("c6_pre",   {v_bs[5], v_ov[5], v_st[5]}, 3'b111);
    rst = 1'b0;
    #1;
    check("c6_async", {busy, done, in_ready, out_valid, dp_stall}, 5'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("c6_hold", {busy, done}, 2'b0);
    end
    @(negedge clk); rst = 1'b1;

    // fresh run of 2 after the abort
    run_case(7, 2, 12);
    check("c7_ov",   v_ov, 32'h0000_0060);
    check("c7_done", v_dn, 32'h0000_0100);
    check("c7_nret", n_ret, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_kernel_a_stream_ctrl
`default_nettype wire
